// File: rtl/s68k_pkg.sv
// s68k_pkg: shared state encoding, register offsets and reset constants for the
// AHB to strobed 68k-style byte bus bridge.
package s68k_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;
    localparam logic [2:0] OFF_TXD  = 3'd0;
    localparam logic [2:0] OFF_RXC  = 3'd1;
    localparam logic [2:0] OFF_CFG  = 3'd2;
    localparam logic [2:0] OFF_STAT = 3'd3;
    localparam int CFG_CKPOL = 8;
    localparam logic [7:0] DIV_RST_DEF = 8'd3;
endpackage

// File: rtl/s68k_cmd_fifo.sv
// s68k_cmd_fifo: synchronous command FIFO; a push while full is accepted when a
// pop happens on the same clock.
module s68k_cmd_fifo
    import s68k_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, rp_q;
    logic         do_push, do_pop;

    assign empty_o = wp_q == rp_q;
    assign full_o  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + ONE;
            if (do_pop) rp_q <= rp_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/ahb_s68k_bridge.sv
// ahb_s68k_bridge: AHB register slave that runs timed byte-wide CS/WR/CKO bus cycles.
// Define S68K_CMDFIFO_EN to queue commands in a FIFO instead of stalling while busy.
module ahb_s68k_bridge
    import s68k_pkg::*;
#(
    parameter int         DW         = 8,
    parameter logic [7:0] DIV_RST    = DIV_RST_DEF,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic [31:0] HRDATA,
    output logic [15:0] S68K_DO,
    input  logic [15:0] S68K_DI,
    output logic        S68K_DIR,
    output logic        S68K_CS,
    output logic        S68K_WR,
    output logic        S68K_CKO
);
    state_t        state_q;
    logic          addr_ok, dp_q, dp_wr_q, dp_cmd, start, busy, full, sample, rxv_d;
    logic          ckpol_q, rxv_q, rd_q, cs_q, wr_q, dir_q, unused;
    logic [2:0]    dp_off_q;
    logic [7:0]    div_q, ph_q;
    logic [DW-1:0] rxd_q, do_q;
    logic [DW:0]   cmd_in, cmd;
    logic [31:0]   hrdata_q, rd_val;

    assign addr_ok = HSEL & HTRANS[1];
    assign dp_cmd  = dp_q & dp_wr_q & ((dp_off_q == OFF_TXD) | (dp_off_q == OFF_RXC));
    assign cmd_in  = {dp_off_q == OFF_RXC, HWDATA[DW-1:0]};

`ifdef S68K_CMDFIFO_EN
    logic empty;
    assign start  = (state_q == ST_IDLE) & ~empty;
    assign busy   = (state_q != ST_IDLE) | ~empty;
    assign HREADY = ~(dp_cmd & full & ~start);
    s68k_cmd_fifo #(.W(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i  (HCLK),
        .rst_ni (HRESETn),
        .push_i (dp_cmd),
        .pop_i  (start),
        .din_i  (cmd_in),
        .dout_o (cmd),
        .full_o (full),
        .empty_o(empty)
    );
`else
    // Commands are taken straight from the data phase; a busy FSM stalls the bus.
    assign start  = (state_q == ST_IDLE) & dp_cmd;
    assign busy   = state_q != ST_IDLE;
    assign HREADY = ~(dp_cmd & busy);
    assign full   = 1'b0;
    assign cmd    = cmd_in;
`endif

    assign rd_val = ((HADDR[4:2] == OFF_TXD) || (HADDR[4:2] == OFF_RXC)) ? 32'(rxd_q)
                  : (HADDR[4:2] == OFF_CFG)  ? 32'({ckpol_q, div_q})
                  : (HADDR[4:2] == OFF_STAT) ? 32'({full, rxv_q, busy}) : '0;
    assign sample = (state_q == ST_STROBE) && (ph_q == 8'd0) && rd_q;
    assign rxv_d  = sample | (rxv_q & ~(addr_ok & HREADY & ~HWRITE & (HADDR[4:2] == OFF_RXC)));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_q     <= 1'b0;
            dp_wr_q  <= 1'b0;
            dp_off_q <= '0;
            hrdata_q <= '0;
            div_q    <= DIV_RST;
            ckpol_q  <= 1'b0;
            rxd_q    <= '0;
            rxv_q    <= 1'b0;
        end else begin
            if (HREADY) begin
                dp_q     <= addr_ok;
                dp_wr_q  <= HWRITE;
                dp_off_q <= HADDR[4:2];
                if (addr_ok) hrdata_q <= HWRITE ? '0 : rd_val;
            end
            if (dp_q && dp_wr_q && dp_off_q == OFF_CFG) begin
                div_q   <= HWDATA[7:0];
                ckpol_q <= HWDATA[CFG_CKPOL];
            end
            if (sample) rxd_q <= S68K_DI[DW-1:0];
            rxv_q <= rxv_d;
        end
    end

    // Every non-idle state lasts DIV+1 clocks; DIV is re-read at each state entry.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            dir_q   <= 1'b0;
            do_q    <= '0;
            rd_q    <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (start) begin
                state_q <= ST_SETUP;
                ph_q    <= div_q;
                cs_q    <= 1'b0;
                wr_q    <= cmd[DW];
                dir_q   <= ~cmd[DW];
                rd_q    <= cmd[DW];
                if (!cmd[DW]) do_q <= cmd[DW-1:0];
            end
        end else if (ph_q != 8'd0) begin
            ph_q <= ph_q - 8'd1;
        end else begin
            state_q <= state_t'(state_q + 2'd1);
            ph_q    <= div_q;
            if (state_q == ST_HOLD) begin
                cs_q  <= 1'b1;
                wr_q  <= 1'b1;
                dir_q <= 1'b0;
            end
        end
    end

    assign HRDATA   = hrdata_q;
    assign S68K_DO  = 16'(do_q);
    assign S68K_DIR = dir_q;
    assign S68K_CS  = cs_q;
    assign S68K_WR  = wr_q;
    assign S68K_CKO = ckpol_q ^ (state_q == ST_STROBE);
    assign unused   = &{1'b0, HADDR, HSIZE, HWDATA, HTRANS, S68K_DI, 32'(FIFO_DEPTH)};
endmodule

// File: tb/tb_ahb_s68k_bridge.sv
// tb_ahb_s68k_bridge: self-checking bench for ahb_s68k_bridge; register vectors,
// directed bus-cycle corners and a randomized run against a cycle-shape model.
module tb_ahb_s68k_bridge;
    logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0;
    logic [31:0] HADDR = '0, HWDATA = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = 3'd2;
    logic [15:0] S68K_DI = '0;
    logic        HREADY, S68K_DIR, S68K_CS, S68K_WR, S68K_CKO;
    logic [31:0] HRDATA;
    logic [15:0] S68K_DO;
    int tests = 0, fails = 0;

    localparam logic [31:0] A_TXD = 32'h00, A_RXC = 32'h04, A_CFG = 32'h08, A_STAT = 32'h0C;

    typedef struct {
        int len, wrl, dirh, ckn, ckst, gap;
        logic [15:0] dout;
        bit idle_lvl, do_ok;
    } obs_t;
    obs_t obs[$];

    typedef struct {
        bit          wr;
        logic [31:0] a, d, exp;
    } vec_t;

    always #5 HCLK = ~HCLK;

    ahb_s68k_bridge dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .S68K_DO(S68K_DO), .S68K_DI(S68K_DI), .S68K_DIR(S68K_DIR), .S68K_CS(S68K_CS),
        .S68K_WR(S68K_WR), .S68K_CKO(S68K_CKO)
    );

    // Pin monitor: one record per CS-low window, sampled mid-cycle.
    initial begin
        obs_t cur;
        bit in_c = 0;
        int gap_c = 0;
        cur.len = 0;
        forever begin
            @(negedge HCLK);
            if (!S68K_CS) begin
                if (!in_c) begin
                    in_c = 1;
                    cur.len = 0; cur.wrl = 0; cur.dirh = 0; cur.ckn = 0; cur.ckst = 0;
                    cur.gap = gap_c; cur.dout = S68K_DO; cur.idle_lvl = S68K_CKO; cur.do_ok = 1;
                end
                cur.len++;
                if (!S68K_WR) cur.wrl++;
                if (S68K_DIR) cur.dirh++;
                if (S68K_DO !== cur.dout) cur.do_ok = 0;
                if (S68K_CKO !== cur.idle_lvl) begin
                    if (cur.ckn == 0) cur.ckst = cur.len;
                    cur.ckn++;
                end
            end else begin
                if (in_c) begin
                    obs.push_back(cur);
                    in_c = 0;
                    gap_c = 0;
                end
                gap_c++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, output int stalls);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a;
        tick();
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
        stalls = 0;
        while (!HREADY && stalls < 500) begin
            tick();
            stalls++;
        end
        if (!HREADY) check("hready_timeout", 32'(HREADY), 32'd1);
        tick();
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a;
        tick();
        HSEL = 0; HTRANS = 2'b00;
        d = HRDATA;
        tick();
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int n = 0;
        ahb_read(A_STAT, s);
        while (s[0] && n < 200) begin
            ahb_read(A_STAT, s);
            n++;
        end
        if (s[0]) check("busy_timeout", s[0], 1'b0);
    endtask

    // Expected shape: three phases of DIV+1 clocks, CKO inverted for the middle one.
    task automatic check_cycle(input bit rd, input logic [7:0] d, input int div, input bit ckpol,
                               output int gap);
        obs_t o;
        int n = 0;
        gap = -1;
        while (obs.size() == 0 && n < 500) begin
            tick();
            n++;
        end
        if (obs.size() == 0) begin
            check("no_bus_cycle", 32'd0, 32'd1);
            return;
        end
        o = obs.pop_front();
        gap = o.gap;
        check("cyc_len", o.len, 3 * (div + 1));
        check("cyc_wr_low", o.wrl, rd ? 0 : 3 * (div + 1));
        check("cyc_dir_high", o.dirh, rd ? 0 : 3 * (div + 1));
        check("cyc_cko_active", o.ckn, div + 1);
        check("cyc_cko_start", o.ckst, div + 2);
        check("cyc_cko_idle", o.idle_lvl, ckpol);
        if (!rd) begin
            check("cyc_do", o.dout, {8'h00, d});
            check("cyc_do_stable", o.do_ok, 1'b1);
        end
    endtask

    initial begin
        vec_t vt[10];
        logic [31:0] rd, d;
        int st, gap, op, m_div;
        bit m_ckpol, m_rxv;
        logic [7:0] m_rxd;

        vt = '{
            '{0, A_CFG,  32'h0,        32'h003},
            '{1, A_CFG,  32'h17F,      32'h0},
            '{0, A_CFG,  32'h0,        32'h17F},
            '{1, A_CFG,  32'hFFFF_F0AB, 32'h0},
            '{0, A_CFG,  32'h0,        32'h0AB},
            '{0, 32'h10, 32'h0,        32'h0},
            '{1, 32'h14, 32'hFFFF,     32'h0},
            '{0, 32'h1C, 32'h0,        32'h0},
            '{0, A_STAT, 32'h0,        32'h0},
            '{1, A_CFG,  32'h003,      32'h0}
        };

        repeat (3) @(posedge HCLK);
        #1;
        check("rst_cs", S68K_CS, 1'b1);
        check("rst_wr", S68K_WR, 1'b1);
        check("rst_dir", S68K_DIR, 1'b0);
        check("rst_cko", S68K_CKO, 1'b0);
        check("rst_hready", HREADY, 1'b1);
        check("rst_do", S68K_DO, 16'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        HRESETn = 1;

        foreach (vt[i]) begin
            if (vt[i].wr) begin
                ahb_write(vt[i].a, vt[i].d, st);
                check($sformatf("vec%0d_nostall", i), st, 0);
            end else begin
                ahb_read(vt[i].a, rd);
                check($sformatf("vec%0d_read", i), rd, vt[i].exp);
            end
        end
        ahb_read(A_TXD, rd);
        check("rxd_reset", rd, 32'h0);

        ahb_write(A_TXD, 32'hFFFF_FFA5, st);
        wait_idle();
        check_cycle(0, 8'hA5, 3, 0, gap);
        ahb_read(A_STAT, rd);
        check("write_stat_idle", rd, 32'h0);

        ahb_write(A_CFG, 32'h0, st);
        S68K_DI = 16'hA53C;
        ahb_write(A_RXC, 32'h1234, st);
        wait_idle();
        check_cycle(1, 8'h00, 0, 0, gap);
        ahb_read(A_STAT, rd);
        check("read_stat_rxv", rd, 32'h2);
        ahb_read(A_RXC, rd);
        check("read_rxd", rd, 32'h3C);
        ahb_read(A_STAT, rd);
        check("read_stat_cleared", rd, 32'h0);

        ahb_write(A_TXD, 32'h11, st);
        check("b2b_first_nostall", st, 0);
        ahb_write(A_TXD, 32'h22, st);
`ifndef S68K_CMDFIFO_EN
        check("b2b_second_stall", st, 2);
`endif
        wait_idle();
        check_cycle(0, 8'h11, 0, 0, gap);
        check_cycle(0, 8'h22, 0, 0, gap);
        check("b2b_idle_gap", gap, 1);

        ahb_write(A_CFG, 32'h101, st);
        check("ckpol_idle_high", S68K_CKO, 1'b1);
        ahb_write(A_TXD, 32'h5A, st);
        wait_idle();
        check_cycle(0, 8'h5A, 1, 1, gap);
        check("ckpol_after_high", S68K_CKO, 1'b1);

`ifdef S68K_CMDFIFO_EN
        ahb_write(A_CFG, 32'h003, st);
        for (int i = 1; i <= 5; i++) begin
            ahb_write(A_TXD, 32'(i), st);
            check($sformatf("fifo_w%0d_nostall", i), st, 0);
        end
        ahb_read(A_STAT, rd);
        check("fifo_full", rd[2], 1'b1);
        ahb_write(A_TXD, 32'h6, st);
        check("fifo_w6_stalls", 32'(st > 0), 32'd1);
        wait_idle();
        for (int i = 1; i <= 6; i++) check_cycle(0, 8'(i), 3, 0, gap);
`endif

        m_div = 0; m_ckpol = 0; m_rxv = 0; m_rxd = 8'h3C;
        ahb_write(A_CFG, 32'h0, st);
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 5);
            if (op == 0) begin
                m_div = $urandom_range(0, 3);
                m_ckpol = 1'($urandom_range(0, 1));
                ahb_write(A_CFG, ($urandom & 32'hFFFF_FE00) | {m_ckpol, 8'(m_div)}, st);
                ahb_read(A_CFG, rd);
                check("rnd_cfg", rd, {23'h0, m_ckpol, 8'(m_div)});
            end else if (op == 1) begin
                d = $urandom;
                ahb_write(A_TXD, d, st);
                wait_idle();
                check_cycle(0, d[7:0], m_div, m_ckpol, gap);
            end else if (op == 2) begin
                S68K_DI = 16'($urandom);
                ahb_write(A_RXC, $urandom, st);
                wait_idle();
                check_cycle(1, 8'h00, m_div, m_ckpol, gap);
                m_rxd = S68K_DI[7:0];
                m_rxv = 1;
            end else if (op == 3) begin
                ahb_read(A_RXC, rd);
                check("rnd_rxc", rd, {24'h0, m_rxd});
                m_rxv = 0;
            end else if (op == 4) begin
                ahb_read(A_STAT, rd);
                check("rnd_stat", rd, {30'h0, m_rxv, 1'b0});
            end else begin
                ahb_read(A_TXD, rd);
                check("rnd_txd_read", rd, {24'h0, m_rxd});
            end
        end

        ahb_write(A_CFG, 32'h003, st);
        ahb_write(A_TXD, 32'h77, st);
        st = 0;
        while (!S68K_CKO && st < 60) begin
            tick();
            st++;
        end
        check("reach_strobe", S68K_CKO, 1'b1);
        HRESETn = 0;
        tick();
        check("mid_rst_cs", S68K_CS, 1'b1);
        check("mid_rst_wr", S68K_WR, 1'b1);
        check("mid_rst_dir", S68K_DIR, 1'b0);
        check("mid_rst_cko", S68K_CKO, 1'b0);
        check("mid_rst_hready", HREADY, 1'b1);
        tick();
        HRESETn = 1;
        obs.delete();
        ahb_read(A_CFG, rd);
        check("mid_rst_cfg", rd, 32'h003);
        ahb_read(A_STAT, rd);
        check("mid_rst_stat", rd, 32'h0);
        ahb_read(A_TXD, rd);
        check("mid_rst_rxd", rd, 32'h0);
        repeat (10) tick();
        check("mid_rst_no_cycle", obs.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
